// File: rtl/cpu_regfile_if.sv
// Bus-side signal bundle for cpu_regfile: bus write/select, fixed taps,
// the in-place op request handshake, flags and a state debug tap.
// Op handshake: a request transfers on a rising edge where op_valid && op_ready;
// op_valid and op* must hold steady until that edge, op_ready never depends on op_valid.
interface cpu_regfile_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] data_in;
    logic [SEL_W-1:0] sel;
    logic             enable_write;
    logic             output_enable;
    logic [WIDTH-1:0] rega;
    logic [WIDTH-1:0] regb;
    logic             op_valid;
    logic [1:0]       op;
    logic [SEL_W-1:0] op_a;
    logic [SEL_W-1:0] op_b;
    logic             op_ready;
    logic             op_done;
    logic             flag_z;
    logic             flag_c;
    logic [1:0]       state_dbg;

    modport master (
        output data_in, sel, enable_write, output_enable,
        output op_valid, op, op_a, op_b,
        input  rega, regb, op_ready, op_done, flag_z, flag_c, state_dbg
    );

    modport slave (
        input  data_in, sel, enable_write, output_enable,
        input  op_valid, op, op_a, op_b,
        output rega, regb, op_ready, op_done, flag_z, flag_c, state_dbg
    );
endinterface

// File: rtl/cpu_regfile.sv
// Parametrised register file: one bus write port, one tri-state bus read
// port, taps on R0/R1, and a small sequencer running INC/DEC/SWAP/CLR in place.
// The tri-state data_out stays a plain module port so the bus pin sits on the
// module boundary; everything else travels through cpu_regfile_if.
module cpu_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    output wire [WIDTH-1:0]  data_out,
    cpu_regfile_if.slave     bus
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SEL_W:0] DEPTH_V = (SEL_W + 1)'(DEPTH);

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SWAP2 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [1:0]       op_q;
    logic [SEL_W-1:0] a_q;
    logic [SEL_W-1:0] b_q;
    logic [WIDTH-1:0] tmp_q;
    logic             done_q;
    logic             z_q;
    logic             c_q;

    logic             sel_ok;
    logic             a_ok;
    logic             b_ok;
    logic [WIDTH-1:0] val_sel;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;

    // Indices at or above DEPTH only exist when DEPTH is not a power of two.
    assign sel_ok = ({1'b0, bus.sel} < DEPTH_V);
    assign a_ok   = ({1'b0, a_q} < DEPTH_V);
    assign b_ok   = ({1'b0, b_q} < DEPTH_V);

    assign val_sel = sel_ok ? regs[bus.sel] : '0;
    assign val_a   = a_ok   ? regs[a_q]     : '0;
    assign val_b   = b_ok   ? regs[b_q]     : '0;
    assign inc_val = val_a + WIDTH'(1);
    assign dec_val = val_a - WIDTH'(1);

    // Bus read has no bypass: a same-cycle write shows up after the edge.
    assign data_out = bus.output_enable ? val_sel : 'z;

    assign bus.rega      = regs[0];
    assign bus.regb      = regs[1];
    assign bus.op_ready  = (state == IDLE);
    assign bus.op_done   = done_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state: SWAP needs a second write cycle for R[b].
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.op_valid) state_nx = EXEC;
            EXEC:    state_nx = (op_q == OP_SWAP) ? SWAP2 : IDLE;
            SWAP2:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Register array, latched op, swap temp, done pulse and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            op_q   <= OP_INC;
            a_q    <= '0;
            b_q    <= '0;
            tmp_q  <= '0;
            done_q <= 1'b0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Bus write lands here, so an op accepted on this edge sees it.
                    if (bus.enable_write && sel_ok) regs[bus.sel] <= bus.data_in;
                    if (bus.op_valid) begin
                        op_q <= bus.op;
                        a_q  <= bus.op_a;
                        b_q  <= bus.op_b;
                    end
                end
                EXEC: begin
                    done_q <= (op_q != OP_SWAP);
                    case (op_q)
                        OP_INC: if (a_ok) begin
                            regs[a_q] <= inc_val;
                            z_q       <= (inc_val == '0);
                            c_q       <= &val_a;
                        end
                        OP_DEC: if (a_ok) begin
                            regs[a_q] <= dec_val;
                            z_q       <= (dec_val == '0);
                            c_q       <= (val_a == '0);
                        end
                        OP_CLR: if (a_ok) regs[a_q] <= '0;
                        default: begin
                            tmp_q <= val_a;
                            if (a_ok && b_ok) regs[a_q] <= val_b;
                        end
                    endcase
                end
                SWAP2: begin
                    done_q <= 1'b1;
                    if (a_ok && b_ok) regs[b_q] <= tmp_q;
                end
                default: ;
            endcase
        end
    end
endmodule
